// File: rtl/inst_mem_loader.sv
// Host-link program loader: packs a length-prefixed byte stream into 32-bit words
// and writes them sequentially into instruction memory. Define INST_LOADER_CHECKSUM_EN
// to require a trailing 8-bit additive checksum byte.
module inst_mem_loader #(
    parameter int unsigned WADDR_W = 17,
    parameter int unsigned LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ASM_W  = WORD_W - BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    // State entered once the header or the data payload is exhausted
`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t TAIL_ST = ST_CSUM;
`else
    localparam state_t TAIL_ST = ST_DONE;
`endif

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [WADDR_W-1:0]  addr_cnt_q, addr_cnt_d;
    logic                in_ready_d, mem_we_d, busy_d, done_d;
    logic [WADDR_W-1:0]  mem_waddr_d;
    logic [WORD_W-1:0]   mem_wdata_d;
    logic                accept;
    logic [LEN_W-1:0]    len_full;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
`endif

    assign accept   = in_valid && in_ready;
    assign len_full = LEN_W'({in_data, len_q[7:0]});

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            bidx_q     <= '0;
            asm_q      <= '0;
            word_cnt_q <= '0;
            addr_cnt_q <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bidx_q     <= bidx_d;
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            in_ready   <= in_ready_d;
            mem_we     <= mem_we_d;
            mem_waddr  <= mem_waddr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state, byte packing and write-buffer logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;
        word_cnt_d  = word_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr;
        mem_wdata_d = mem_wdata;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LEN_LO;
                    bidx_d     = '0;
                    word_cnt_d = '0;
                    addr_cnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = LEN_W'(in_data);
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = len_full;
                    state_d = (len_full == '0) ? TAIL_ST : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + in_data;
`endif
                    case (bidx_q)
                        2'd0: asm_d[23:16] = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[7:0]   = in_data;
                        default: begin
                            // Word complete: hand off to the write buffer, keep accepting
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {asm_q, in_data};
                            mem_waddr_d = addr_cnt_q;
                            addr_cnt_d  = addr_cnt_q + WADDR_W'(1);
                            word_cnt_d  = word_cnt_q + LEN_W'(1);
                            if (word_cnt_q == len_q - LEN_W'(1)) begin
                                state_d = TAIL_ST;
                            end
                        end
                    endcase
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    err_d   = (in_data != sum_q);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
`ifdef INST_LOADER_CHECKSUM_EN
                     (state_d == ST_CSUM) ||
`endif
                     (state_d == ST_DATA);
        busy_d     = in_ready_d;
        done_d     = (state_d == ST_DONE);
    end

endmodule
